da_spi_serializer: RTL and testbench



---
 rtl/da_spi_serializer.sv | 154 +++++++++++++++
 tb/tb_da_spi_serializer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/da_spi_serializer.sv
// Serialises 8-bit samples into 16-bit SYNC/SCLK/DIN frames for a DAC081S101-style DAC.
// Optional DA_HOLD_LAST_EN adds a one-entry pending buffer for back-to-back frames.
module da_spi_serializer #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned FRAME_GAP = 2
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic [7:0] da_data,
  input  logic       da_valid,
  output logic       da_ready,
  output logic       dac_sync_n,
  output logic       dac_sclk,
  output logic       dac_din,
  output logic       frame_done
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GapW = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(FRAME_GAP - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StLoad  = 2'd1;
  localparam logic [1:0] StShift = 2'd2;
  localparam logic [1:0] StGap   = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic            sclk_low_q, sclk_low_d;
  logic [3:0]      bit_q, bit_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [15:0]     shift_q, shift_d;
  logic            accept;

  function automatic logic [15:0] frame_word(input logic [7:0] d);
    return {4'b0000, d, 4'b0000};
  endfunction

`ifdef DA_HOLD_LAST_EN
  logic       pend_full_q, pend_full_d;
  logic [7:0] pend_data_q, pend_data_d;
  logic       gap_end;

  assign gap_end  = (state_q == StGap) && (gap_q == GapLast);
  assign da_ready = !rst && !pend_full_q;
`else
  assign da_ready = !rst && (state_q == StIdle);
`endif

  assign accept = da_valid && da_ready;

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    sclk_low_d = sclk_low_q;
    bit_d      = bit_q;
    gap_d      = gap_q;
    shift_d    = shift_q;
`ifdef DA_HOLD_LAST_EN
    pend_full_d = pend_full_q;
    pend_data_d = pend_data_q;
    // Samples arriving mid-frame park here; the one at GAP end is loaded directly
    if (accept && (state_q != StIdle) && !gap_end) begin
      pend_full_d = 1'b1;
      pend_data_d = da_data;
    end
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StLoad;
          shift_d = frame_word(da_data);
        end
      end
      StLoad: begin
        state_d    = StShift;
        div_d      = '0;
        sclk_low_d = 1'b0;
        bit_d      = 4'd0;
      end
      StShift: begin
        if (div_q == DivLast) begin
          div_d = '0;
          if (!sclk_low_q) begin
            sclk_low_d = 1'b1;
          end else begin
            sclk_low_d = 1'b0;
            if (bit_q == 4'd15) begin
              state_d = StGap;
              gap_d   = '0;
            end else begin
              bit_d   = bit_q + 4'd1;
              shift_d = {shift_q[14:0], 1'b0};
            end
          end
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          state_d = StIdle;
`ifdef DA_HOLD_LAST_EN
          if (pend_full_q) begin
            state_d     = StLoad;
            shift_d     = frame_word(pend_data_q);
            pend_full_d = 1'b0;
          end else if (accept) begin
            state_d = StLoad;
            shift_d = frame_word(da_data);
          end
`endif
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q    <= StIdle;
      div_q      <= '0;
      sclk_low_q <= 1'b0;
      bit_q      <= 4'd0;
      gap_q      <= '0;
      shift_q    <= 16'h0000;
`ifdef DA_HOLD_LAST_EN
      pend_full_q <= 1'b0;
      pend_data_q <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      sclk_low_q <= sclk_low_d;
      bit_q      <= bit_d;
      gap_q      <= gap_d;
      shift_q    <= shift_d;
`ifdef DA_HOLD_LAST_EN
      pend_full_q <= pend_full_d;
      pend_data_q <= pend_data_d;
`endif
    end
  end

  // Outputs are forced to idle levels combinationally while rst is high
  assign dac_sync_n = rst || !((state_q == StLoad) || (state_q == StShift));
  assign dac_sclk   = rst || !((state_q == StShift) && sclk_low_q);
  assign dac_din    = !rst && ((state_q == StLoad) || (state_q == StShift)) && shift_q[15];
  assign frame_done = !rst && (state_q == StGap) && (gap_q == '0);

endmodule

// File: tb/tb_da_spi_serializer.sv
// Scoreboard bench: two DUTs (CLK_DIV/FRAME_GAP = 2/2 and 1/1), directed plus random samples.
module tb_da_spi_serializer;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic [1:0] rst;
  logic [1:0] valid;
  logic [7:0] data [2];
  logic [1:0] ready, sync_n, sclk, din, done;

  int errors = 0;
  int checks = 0;
  int frames_rx[2];
  int done_cnt[2];
  int gap_min[2];
  int exp_left[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned CD = (g == 0) ? 2 : 1;
    localparam int unsigned FG = (g == 0) ? 2 : 1;

    da_spi_serializer #(.CLK_DIV(CD), .FRAME_GAP(FG)) u_dut (
      .sys_clk   (sys_clk),
      .rst       (rst[g]),
      .da_data   (data[g]),
      .da_valid  (valid[g]),
      .da_ready  (ready[g]),
      .dac_sync_n(sync_n[g]),
      .dac_sclk  (sclk[g]),
      .dac_din   (din[g]),
      .frame_done(done[g])
    );

    logic [15:0] exp_q[$];
    logic [15:0] bits;
    bit          in_frame = 0;
    bit          gap_valid = 0;
    bit          prev_sclk = 1;
    int          low_cnt, high_cnt, nbits;

    // Expected word is pushed on the handshake; frames are decoded from the pins
    always @(negedge sys_clk) begin
      if (rst[g]) begin
        chk($sformatf("dut%0d reset outputs {sync,sclk,din,done,ready}", g),
            {sync_n[g], sclk[g], din[g], done[g], ready[g]}, 5'b11000);
        exp_q.delete();
        in_frame  = 0;
        gap_valid = 0;
        prev_sclk = 1;
      end else begin
        if (valid[g] && ready[g]) exp_q.push_back({4'h0, data[g], 4'h0});
        if (!sync_n[g]) begin
          if (!in_frame) begin
            in_frame = 1;
            low_cnt  = 0;
            nbits    = 0;
            bits     = 16'h0;
            if (gap_valid && high_cnt < gap_min[g]) gap_min[g] = high_cnt;
          end
          low_cnt++;
          if (prev_sclk && !sclk[g]) begin
            bits = {bits[14:0], din[g]};
            nbits++;
          end
          if (done[g]) chk($sformatf("dut%0d frame_done inside frame", g), done[g], 1'b0);
        end else if (in_frame) begin
          in_frame = 0;
          frames_rx[g]++;
          chk($sformatf("dut%0d sync_n low cycles", g), low_cnt, 1 + 32 * CD);
          chk($sformatf("dut%0d sclk falling edges", g), nbits, 16);
          chk($sformatf("dut%0d frame had an accept", g), exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) chk($sformatf("dut%0d frame word", g), bits, exp_q.pop_front());
          chk($sformatf("dut%0d frame_done at first gap cycle", g), done[g], 1'b1);
          high_cnt  = 1;
          gap_valid = 1;
        end else begin
          high_cnt++;
          if (done[g]) chk($sformatf("dut%0d spurious frame_done", g), done[g], 1'b0);
        end
        prev_sclk = sclk[g];
        if (done[g]) done_cnt[g]++;
      end
      exp_left[g] = exp_q.size();
    end
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Offer d until taken; leaves the bench one step after the accepting edge.
  task automatic send(input int g, input logic [7:0] d);
    int k = 0;
    valid[g] = 1'b1;
    data[g]  = d;
    @(negedge sys_clk);
    while (!ready[g] && k < 500) begin
      k++;
      @(negedge sys_clk);
    end
    chk($sformatf("dut%0d accept within bound", g), k < 500, 1'b1);
    step();
    valid[g] = 1'b0;
    data[g]  = 8'($urandom);
  endtask

  // Counts cycles with da_ready low; ends on the negedge where ready is high.
  task automatic count_low(input int g, output int k);
    k = 0;
    @(negedge sys_clk);
    while (!ready[g] && k < 500) begin
      k++;
      @(negedge sys_clk);
    end
  endtask

  task automatic drain();
    int k = 0;
    @(negedge sys_clk);
    while (!(exp_left[0] == 0 && exp_left[1] == 0 && sync_n == 2'b11 && ready == 2'b11)
           && k < 3000) begin
      k++;
      @(negedge sys_clk);
    end
    chk("drain within bound", k < 3000, 1'b1);
    step();
  endtask

  task automatic drive_random(input int g, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) step();
      send(g, 8'($urandom));
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int k, k2, base_f, base_d;
`ifdef DA_HOLD_LAST_EN
    localparam bit Hold = 1'b1;
`else
    localparam bit Hold = 1'b0;
`endif
    for (int i = 0; i < 2; i++) begin
      frames_rx[i] = 0;
      done_cnt[i]  = 0;
      gap_min[i]   = 999;
      exp_left[i]  = 0;
      data[i]      = 8'h5A;
    end
    rst   = 2'b11;
    valid = 2'b11;
    repeat (4) @(posedge sys_clk);
    #1;
    valid = 2'b00;
    rst   = 2'b00;
    @(negedge sys_clk);
    chk("ready right after reset release", ready, 2'b11);
    chk("no frame during reset", frames_rx[0] + frames_rx[1], 0);
    step();

    // Single sample A5 on the default-parameter DUT
    send(0, 8'hA5);
    count_low(0, k);
    chk("A5 ready-low cycles", k, Hold ? 0 : 67);
    drain();
    chk("A5 frames", frames_rx[0], 1);
    chk("A5 frame_done pulses", done_cnt[0], 1);

    // Back-to-back stream 00, FF, 5A with valid held
    gap_min[0] = 999;
    base_f = frames_rx[0];
    valid[0] = 1'b1;
    data[0]  = 8'h00;
    step();
    data[0] = 8'hFF;
    count_low(0, k);
    chk("b2b second accept wait", k, Hold ? 0 : 67);
    step();
    data[0] = 8'h5A;
    count_low(0, k2);
    chk("b2b third accept wait", k2, Hold ? 66 : 67);
    step();
    valid[0] = 1'b0;
    drain();
    chk("b2b frames", frames_rx[0] - base_f, 3);
    chk("b2b sync_n high between frames", gap_min[0], Hold ? 2 : 3);

    // Reset during bit 7 of frame 3C abandons it
    base_f = frames_rx[0];
    base_d = done_cnt[0];
    send(0, 8'h3C);
    repeat (30) step();
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    @(negedge sys_clk);
    chk("sync_n high after mid-frame reset", sync_n[0], 1'b1);
    step();
    chk("abandoned frame not counted", frames_rx[0] - base_f, 0);
    chk("no frame_done for abandoned frame", done_cnt[0] - base_d, 0);
    send(0, 8'hC3);
    drain();
    chk("C3 frame after reset", frames_rx[0] - base_f, 1);
    chk("C3 frame_done", done_cnt[0] - base_d, 1);

    // CLK_DIV=1, FRAME_GAP=1 DUT with 81
    send(1, 8'h81);
    count_low(1, k);
    chk("81 ready-low cycles", k, Hold ? 0 : 34);
    drain();
    chk("81 frames", frames_rx[1], 1);

    // Random samples on both DUTs concurrently
    base_f = frames_rx[0];
    base_d = frames_rx[1];
    fork
      drive_random(0, 12);
      drive_random(1, 12);
    join
    drain();
    chk("random frames dut0", frames_rx[0] - base_f, 12);
    chk("random frames dut1", frames_rx[1] - base_d, 12);
    chk("scoreboard empty dut0", exp_left[0], 0);
    chk("scoreboard empty dut1", exp_left[1], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
